// File: rtl/mem_arbiter.sv
// Serialises the core's fetch and data request ports onto one memory port; data wins by default,
// a saturating streak counter forces a fetch grant after MAX_D_STREAK data grants while a fetch waits.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_data,
  output logic        m_valid,
  output logic        m_is_write,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic [63:0] m_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic          abandon_q;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [2:0]    lat_size;
  logic [7:0]    lat_strobe;

  logic busy;
  logic busy_i;
  logic busy_d;
  logic grant_d;
  logic grant_i;
  logic owner_valid;
  logic abandon_now;

  assign busy   = (state != IDLE);
  assign busy_i = (state == BUSY_I);
  assign busy_d = (state == BUSY_D);

  // streak never exceeds STREAK_MAX, so exactly one of these fires when anything is requested
  assign grant_d = (state == IDLE) && d_valid && (!i_valid || (streak < STREAK_MAX));
  assign grant_i = (state == IDLE) && i_valid && (!d_valid || (streak == STREAK_MAX));

  // a requester dropping valid in the completion cycle must also suppress its pulse
  assign owner_valid = busy_i ? i_valid : d_valid;
  assign abandon_now = abandon_q | ~owner_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      streak     <= '0;
      abandon_q  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
      lat_strobe <= '0;
    end else if (grant_d) begin
      state      <= BUSY_D;
      abandon_q  <= 1'b0;
      lat_addr   <= d_addr;
      lat_size   <= d_size;
      lat_strobe <= d_strobe;
      lat_wdata  <= d_wdata;
      if (!i_valid)
        streak <= '0;
      else if (streak != STREAK_MAX)
        streak <= streak + SW'(1);
    end else if (grant_i) begin
      state      <= BUSY_I;
      abandon_q  <= 1'b0;
      streak     <= '0;
      lat_addr   <= i_addr;
      lat_size   <= 3'b010;
      lat_strobe <= '0;
      lat_wdata  <= '0;
    end else if (busy) begin
      if (!owner_valid)
        abandon_q <= 1'b1;
      if (m_ready)
        state <= IDLE;
    end
  end

  // memory side is a pure function of state and the latched request, so reset clears it at once
  assign m_valid    = busy;
  assign m_is_write = busy_d & (|lat_strobe);
  assign m_addr     = busy ? lat_addr   : '0;
  assign m_size     = busy ? lat_size   : '0;
  assign m_strobe   = busy ? lat_strobe : '0;
  assign m_wdata    = busy ? lat_wdata  : '0;

  assign i_data_ok = busy_i & m_ready & ~abandon_now;
  assign d_data_ok = busy_d & m_ready & ~abandon_now;

  assign i_data = i_data_ok ? (lat_addr[2] ? m_rdata[63:32] : m_rdata[31:0]) : '0;
  assign d_data = (d_data_ok & ~m_is_write) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle vectors for mem_arbiter plus hand sequences for starvation and async reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_data;
  logic        m_valid;
  logic        m_is_write;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic [63:0] m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_size(m_size),
    .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  typedef struct {
    string       name;
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  ds;
    logic [7:0]  dst;
    logic [63:0] dw;
    logic        mr;
    logic [63:0] mrd;
    logic        e_mv;
    logic        e_mw;
    logic [63:0] e_ma;
    logic [2:0]  e_ms;
    logic [7:0]  e_mst;
    logic [63:0] e_mwd;
    logic        e_iok;
    logic [31:0] e_id;
    logic        e_dok;
    logic [63:0] e_dd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [238:0] outs();
    return {m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
            i_data_ok, i_data, d_data_ok, d_data};
  endfunction

  task automatic check(input string name, input logic [238:0] act, input logic [238:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name,
                     input logic iv, input logic [63:0] ia,
                     input logic dv, input logic [63:0] da, input logic [2:0] ds,
                     input logic [7:0] dst, input logic [63:0] dw,
                     input logic mr, input logic [63:0] mrd,
                     input logic e_mv, input logic e_mw, input logic [63:0] e_ma,
                     input logic [2:0] e_ms, input logic [7:0] e_mst, input logic [63:0] e_mwd,
                     input logic e_iok, input logic [31:0] e_id,
                     input logic e_dok, input logic [63:0] e_dd);
    vec_t v;
    v.name = name; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.ds = ds;
    v.dst = dst; v.dw = dw; v.mr = mr; v.mrd = mrd;
    v.e_mv = e_mv; v.e_mw = e_mw; v.e_ma = e_ma; v.e_ms = e_ms; v.e_mst = e_mst;
    v.e_mwd = e_mwd; v.e_iok = e_iok; v.e_id = e_id; v.e_dok = e_dok; v.e_dd = e_dd;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_size = '0;
    d_strobe = '0; d_wdata = '0; m_ready = 0; m_rdata = '0;
  endtask

  localparam logic [63:0] FA  = 64'h0000_0000_8000_0004;
  localparam logic [63:0] FB  = 64'h0000_0000_8000_0008;
  localparam logic [63:0] FC  = 64'h0000_0000_8000_0040;
  localparam logic [63:0] FN  = 64'h0000_0000_8000_0100;
  localparam logic [63:0] DA  = 64'h0000_0000_8001_0000;
  localparam logic [63:0] DW  = 64'h0000_0000_8002_0000;
  localparam logic [63:0] DX  = 64'h0000_0000_8003_0000;
  localparam logic [63:0] WD  = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] R1  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R2  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] R3  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] R4  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] R5  = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] RF  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    string exp_seq;
    int    n;
    byte   kind;

    clear_inputs();
    reset = 0;
    #1;
    check("reset_outputs", outs(), '0);
    #20;
    @(negedge clk);
    reset = 1;

    // single fetch, memory ready two cycles after m_valid; addr[2]=1 selects upper word
    add("f_req",   1, FA, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("f_wait1", 1, FA, 0, 0, 0, 0, 0, 0, 0,   1, 0, FA, 2, 0, 0,  0, 0,            0, 0);
    add("f_wait2", 1, FA, 0, 0, 0, 0, 0, 0, 0,   1, 0, FA, 2, 0, 0,  0, 0,            0, 0);
    add("f_resp",  1, FA, 0, 0, 0, 0, 0, 1, R1,  1, 0, FA, 2, 0, 0,  1, 32'h11112222, 0, 0);
    add("f_idle",  0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    // simultaneous requests: data first, fetch in the following IDLE
    add("s_req",   1, FB, 1, DA, 3, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("s_dresp", 1, FB, 1, DA, 3, 0, 0, 1, R2, 1, 0, DA, 3, 0, 0,  0, 0,            1, R2);
    add("s_idle",  1, FB, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("s_iresp", 1, FB, 0, 0,  0, 0, 0, 1, R3, 1, 0, FB, 2, 0, 0,  1, 32'h77778888, 0, 0);
    add("s_done",  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    // write held on the memory port until m_ready
    add("w_req",   0, 0, 1, DW, 3, 8'hF0, WD, 0, 0, 0, 0, 0,  0, 0,     0,  0, 0, 0, 0);
    add("w_hold1", 0, 0, 1, DW, 3, 8'hF0, WD, 0, 0, 1, 1, DW, 3, 8'hF0, WD, 0, 0, 0, 0);
    add("w_hold2", 0, 0, 1, DW, 3, 8'hF0, WD, 0, 0, 1, 1, DW, 3, 8'hF0, WD, 0, 0, 0, 0);
    add("w_ack",   0, 0, 1, DW, 3, 8'hF0, WD, 1, 0, 1, 1, DW, 3, 8'hF0, WD, 0, 0, 1, 0);
    add("w_idle",  0, 0, 0, 0,  0, 0,     0,  0, 0, 0, 0, 0,  0, 0,     0,  0, 0, 0, 0);
    // abandoned fetch completes silently, re-raised fetch is served afterwards
    add("a_req",   1, FC, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("a_busy",  1, FC, 0, 0, 0, 0, 0, 0, 0,   1, 0, FC, 2, 0, 0,  0, 0,            0, 0);
    add("a_drop",  0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, FC, 2, 0, 0,  0, 0,            0, 0);
    add("a_rerz",  1, FN, 0, 0, 0, 0, 0, 0, 0,   1, 0, FC, 2, 0, 0,  0, 0,            0, 0);
    add("a_done",  1, FN, 0, 0, 0, 0, 0, 1, R4,  1, 0, FC, 2, 0, 0,  0, 0,            0, 0);
    add("a_idle",  1, FN, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("a_resp",  1, FN, 0, 0, 0, 0, 0, 1, R5,  1, 0, FN, 2, 0, 0,  1, 32'hBBBBCCCC, 0, 0);
    add("a_end",   0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    // owner drops valid in the m_ready cycle; m_ready in IDLE is ignored
    add("x_req",   0, 0, 1, DX, 2, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("x_drop",  0, 0, 0, 0,  0, 0, 0, 1, RF,  1, 0, DX, 2, 0, 0,  0, 0,            0, 0);
    add("x_idle1", 0, 0, 0, 0,  0, 0, 0, 1, RF,  0, 0, 0,  0, 0, 0,  0, 0,            0, 0);
    add("x_idle2", 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0,            0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      i_valid = vecs[k].iv; i_addr = vecs[k].ia;
      d_valid = vecs[k].dv; d_addr = vecs[k].da; d_size = vecs[k].ds;
      d_strobe = vecs[k].dst; d_wdata = vecs[k].dw;
      m_ready = vecs[k].mr; m_rdata = vecs[k].mrd;
      #1;
      check(vecs[k].name, outs(),
            {vecs[k].e_mv, vecs[k].e_mw, vecs[k].e_ma, vecs[k].e_ms, vecs[k].e_mst,
             vecs[k].e_mwd, vecs[k].e_iok, vecs[k].e_id, vecs[k].e_dok, vecs[k].e_dd});
    end

    // starvation guard: both held, memory answers one cycle after each grant
    @(negedge clk);
    clear_inputs();
    i_valid = 1; i_addr = 64'h0000_0000_8000_0200;
    d_valid = 1; d_addr = 64'h0000_0000_8004_0000; d_size = 3;
    exp_seq = "DDDDIDDDDI";
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      @(negedge clk);
      m_ready = 0;
      #1;
      if (m_valid) begin
        kind = (m_addr == 64'h0000_0000_8000_0200) ? "I" : "D";
        checks++;
        if (kind != exp_seq[n]) begin
          errors++;
          $display("FAIL starve_grant%0d: got %c expected %c", n, kind, exp_seq[n]);
        end
        n++;
        m_ready = 1;
        m_rdata = 64'h0123_4567_89AB_CDEF;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants expected 10", n);
    end
    @(negedge clk);
    clear_inputs();

    // asynchronous reset mid BUSY_D with m_ready low
    @(negedge clk);
    d_valid = 1; d_addr = 64'h0000_0000_8005_0000; d_size = 3;
    @(posedge clk);
    #1;
    check("rst_busy", {238'b0, m_valid}, 239'd1);
    #2;
    reset = 0;
    #1;
    check("rst_async", outs(), '0);
    d_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_ready = 1; m_rdata = RF;
      #1;
      check($sformatf("rst_after%0d", k), outs(), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
